// File: rtl/dropout_scheduler_if.sv
// Sample stream bundle for the dropout scheduler: upstream valid/ready input
// and downstream valid/ready output carrying the masked sample and its mask.
interface dropout_scheduler_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic [N-1:0] out_mask;
  logic         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mask
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mask
  );
endinterface

// File: rtl/dropout_scheduler.sv
// Burst sequencer for the random-dropout datapath: latches config, masks each
// accepted sample with an LFSR-derived keep mask and counts dropped bits.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; cfg_load honoured here only
//   S_RUN   | accepting samples until the burst count is exhausted
//   S_DRAIN | last sample accepted, waiting for its output handshake
//   S_DONE  | one-cycle done pulse, then back to idle
module dropout_scheduler #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_load,
  input  logic [15:0]          cfg_seed,
  input  logic [8:0]           cfg_keep,
  input  logic [7:0]           cfg_burst,
  input  logic                 start,
  input  logic                 abort,
  dropout_scheduler_if.slave   stream,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     drop_count
);

  localparam logic [15:0] SEED_DFLT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        seed_q, seed_d;
  logic [8:0]         keep_q, keep_d;
  logic [7:0]         burst_q, burst_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [8:0]         remaining_q, remaining_d;
  logic               out_valid_q, out_valid_d;
  logic [N-1:0]       out_data_q, out_data_d;
  logic [N-1:0]       out_mask_q, out_mask_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;

  logic               in_ready_c;
  logic               accept;
  logic               out_hs;
  logic [N-1:0]       mask_c;
  logic [7:0]         r8;
  logic [4:0]         ones_c;
  logic [4:0]         drops_c;
  logic [CNT_W:0]     sum_c;

  // Bit i compares the low byte of the LFSR rotated left by i against keep.
  always_comb begin
    mask_c = '0;
    r8     = '0;
    ones_c = '0;
    for (int i = 0; i < N; i++) begin
      r8        = 8'((lfsr_q << i) | (lfsr_q >> (16 - i)));
      mask_c[i] = ({1'b0, r8} < keep_q);
      ones_c    = ones_c + 5'(mask_c[i]);
    end
    drops_c = 5'(N) - ones_c;
    sum_c   = {1'b0, drop_count_q} + (CNT_W+1)'(drops_c);
  end

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    keep_d       = keep_q;
    burst_d      = burst_q;
    lfsr_d       = lfsr_q;
    remaining_d  = remaining_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_mask_d   = out_mask_q;
    drop_count_d = drop_count_q;

    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    out_hs     = out_valid_q && stream.out_ready;
    // abort also closes the input so no sample slips in on the abort cycle
    in_ready_c = (state_q == S_RUN) && !abort && (!out_valid_q || stream.out_ready);
    accept     = in_ready_c && stream.in_valid;

    case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          seed_d  = cfg_seed;
          keep_d  = cfg_keep;
          burst_d = cfg_burst;
        end
        if (start) begin
          state_d      = S_RUN;
          remaining_d  = {(burst_d == 8'd0), burst_d};
          drop_count_d = '0;
          lfsr_d       = (seed_d == 16'h0000) ? SEED_DFLT : seed_d;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept && (remaining_q == 9'd1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_hs) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      remaining_d  = remaining_q - 9'd1;
      out_valid_d  = 1'b1;
      out_data_d   = stream.in_data & mask_c;
      out_mask_d   = mask_c;
      drop_count_d = sum_c[CNT_W] ? '1 : sum_c[CNT_W-1:0];
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    if (abort && ((state_q == S_RUN) || (state_q == S_DRAIN))) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      seed_q       <= SEED_DFLT;
      keep_q       <= 9'd256;
      burst_q      <= 8'd0;
      lfsr_q       <= SEED_DFLT;
      remaining_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_mask_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      keep_q       <= keep_d;
      burst_q      <= burst_d;
      lfsr_q       <= lfsr_d;
      remaining_q  <= remaining_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_mask_q   <= out_mask_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign stream.in_ready  = in_ready_c;
  assign stream.out_valid = out_valid_q;
  assign stream.out_data  = out_data_q;
  assign stream.out_mask  = out_mask_q;
  assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_dropout_scheduler.sv
// Directed bench for dropout_scheduler: a table of burst configurations checked
// against a small LFSR/mask model, plus hand-written stall, abort and reset cases.
module tb_dropout_scheduler;
  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             cfg_load  = 1'b0;
  logic [15:0]      cfg_seed  = '0;
  logic [8:0]       cfg_keep  = '0;
  logic [7:0]       cfg_burst = '0;
  logic             start     = 1'b0;
  logic             abort     = 1'b0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] drop_count;

  dropout_scheduler_if #(.N(N)) sif ();

  dropout_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_seed   (cfg_seed),
    .cfg_keep   (cfg_keep),
    .cfg_burst  (cfg_burst),
    .start      (start),
    .abort      (abort),
    .stream     (sif.slave),
    .busy       (busy),
    .done       (done),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] seed;
    logic [8:0]  keep;
    logic [7:0]  burst;
    logic [7:0]  data;
    int          exp_drop;   // hand value, or -1 to take the model's
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  logic [7:0] q_data[$];
  logic [7:0] q_mask[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sif.in_valid && sif.in_ready) acc_cnt++;
    if (sif.out_valid && sif.out_ready) begin
      q_data.push_back(sif.out_data);
      q_mask.push_back(sif.out_mask);
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] m_adv(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [7:0] m_mask(input logic [15:0] s, input logic [8:0] keep);
    logic [31:0] d;
    logic [7:0]  m;
    d = {s, s};
    for (int i = 0; i < 8; i++) m[i] = ({1'b0, d[16-i +: 8]} < keep);
    return m;
  endfunction

  task automatic compare_model(input logic [15:0] seed, input logic [8:0] keep, input int n,
                               input logic [7:0] data, input int q0,
                               output int errs, output int drop);
    logic [15:0] s;
    logic [7:0]  m;
    s    = (seed == 16'h0000) ? 16'hACE1 : seed;
    errs = 0;
    drop = 0;
    for (int k = 0; k < n; k++) begin
      m    = m_mask(s, keep);
      drop = drop + 8 - $countones(m);
      if (q0 + k >= q_data.size()) errs++;
      else if (q_data[q0+k] !== (data & m) || q_mask[q0+k] !== m) errs++;
      s = m_adv(s);
    end
  endtask

  task automatic cfg_start(input logic [15:0] seed, input logic [8:0] keep, input logic [7:0] burst);
    @(posedge clk); #1;
    cfg_seed = seed; cfg_keep = keep; cfg_burst = burst;
    cfg_load = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; start = 1'b0;
  endtask

  task automatic wait_acc(input int a0, input int n, input int limit);
    int c;
    c = 0;
    while ((acc_cnt - a0) < n && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic wait_done(input int d0, input int limit);
    int c;
    c = 0;
    while (done_cnt == d0 && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  vec_t vecs[7];
  int   rec_q0[7];

  initial begin
    int a0, q0, d0, n, errs, drop, same;
    logic [7:0] hold_d, hold_m;
    int stall_err;

    vecs[0] = '{16'hACE1, 9'd256, 8'd4,  8'hA5, 0};
    vecs[1] = '{16'h1234, 9'd0,   8'd3,  8'hFF, 24};
    vecs[2] = '{16'h0000, 9'd128, 8'd16, 8'h5A, -1};
    vecs[3] = '{16'h0001, 9'd128, 8'd16, 8'hFF, -1};
    vecs[4] = '{16'h1234, 9'd200, 8'd10, 8'hC3, -1};
    vecs[5] = '{16'hBEEF, 9'd1,   8'd5,  8'hFF, -1};
    vecs[6] = '{16'h00FF, 9'd100, 8'd1,  8'hFF, -1};

    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      int'(busy), 0);
    check("rst_done",      int'(done), 0);
    check("rst_in_ready",  int'(sif.in_ready), 0);
    check("rst_out_valid", int'(sif.out_valid), 0);
    check("rst_out_data",  int'(sif.out_data), 0);
    check("rst_out_mask",  int'(sif.out_mask), 0);
    check("rst_drop",      int'(drop_count), 0);

    // start on default config with no input
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_busy",      int'(busy), 1);
    check("start_in_ready",  int'(sif.in_ready), 1);
    check("start_out_valid", int'(sif.out_valid), 0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);
    check("abort_no_done",   done_cnt, 0);

    for (int r = 0; r < 7; r++) begin
      a0 = acc_cnt; q0 = q_data.size(); d0 = done_cnt;
      rec_q0[r] = q0;
      n = (vecs[r].burst == 8'd0) ? 256 : int'(vecs[r].burst);
      cfg_start(vecs[r].seed, vecs[r].keep, vecs[r].burst);
      sif.in_data = vecs[r].data; sif.in_valid = 1'b1; sif.out_ready = 1'b1;
      wait_acc(a0, n, n + 50);
      sif.in_valid = 1'b0;
      wait_done(d0, 50);
      @(negedge clk);
      compare_model(vecs[r].seed, vecs[r].keep, n, vecs[r].data, q0, errs, drop);
      check($sformatf("v%0d_accepts", r),  acc_cnt - a0, n);
      check($sformatf("v%0d_outputs", r),  q_data.size() - q0, n);
      check($sformatf("v%0d_samples", r),  errs, 0);
      check($sformatf("v%0d_drop", r),     int'(drop_count), drop);
      if (vecs[r].exp_drop >= 0)
        check($sformatf("v%0d_drop_hand", r), int'(drop_count), vecs[r].exp_drop);
      check($sformatf("v%0d_done_cnt", r), done_cnt - d0, 1);
      check($sformatf("v%0d_done_lat", r), done_cyc - last_hs_cyc, 1);
      check($sformatf("v%0d_idle", r),     int'(busy), 0);
    end

    // seed 0 maps to ACE1: first two masks at keep 128 worked out by hand
    check("seed0_mask0", int'(q_mask[rec_q0[2]]),     8'h78);
    check("seed0_mask1", int'(q_mask[rec_q0[2] + 1]), 8'hF1);
    same = 0;
    for (int k = 0; k < 16; k++)
      if (q_mask[rec_q0[2] + k] === q_mask[rec_q0[3] + k]) same++;
    check("seed_runs_differ", int'(same < 16), 1);

    // backpressure mid-burst
    a0 = acc_cnt; q0 = q_data.size(); d0 = done_cnt;
    cfg_start(16'hACE1, 9'd128, 8'd6);
    sif.in_data = 8'h96; sif.in_valid = 1'b1; sif.out_ready = 1'b1;
    wait_acc(a0, 2, 50);
    sif.out_ready = 1'b0;
    hold_d = sif.out_data; hold_m = sif.out_mask;
    stall_err = 0;
    repeat (3) begin
      @(negedge clk);
      if (sif.in_ready !== 1'b0 || sif.out_valid !== 1'b1 ||
          sif.out_data !== hold_d || sif.out_mask !== hold_m) stall_err++;
    end
    check("stall_stable",  stall_err, 0);
    check("stall_mask",    int'(hold_m), 8'hF1);
    check("stall_accepts", acc_cnt - a0, 2);
    @(posedge clk); #1 sif.out_ready = 1'b1;
    wait_acc(a0, 6, 50);
    sif.in_valid = 1'b0;
    wait_done(d0, 50);
    compare_model(16'hACE1, 9'd128, 6, 8'h96, q0, errs, drop);
    check("stall_samples", errs, 0);
    check("stall_outputs", q_data.size() - q0, 6);
    check("stall_done",    done_cnt - d0, 1);

    // abort after the second accept
    a0 = acc_cnt; q0 = q_data.size(); d0 = done_cnt;
    cfg_start(16'h5555, 9'd64, 8'd6);
    sif.in_data = 8'hF0; sif.in_valid = 1'b1;
    wait_acc(a0, 2, 50);
    abort = 1'b1; sif.in_valid = 1'b0;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy",      int'(busy), 0);
    check("abort_out_valid", int'(sif.out_valid), 0);
    repeat (5) @(negedge clk);
    compare_model(16'h5555, 9'd64, 2, 8'hF0, q0, errs, drop);
    check("abort_drop_held", int'(drop_count), drop);
    check("abort_accepts",   acc_cnt - a0, 2);
    check("abort_no_done2",  done_cnt - d0, 0);

    // cfg_load and start during RUN are ignored
    a0 = acc_cnt; q0 = q_data.size(); d0 = done_cnt;
    cfg_start(16'hACE1, 9'd256, 8'd3);
    cfg_seed = 16'h0001; cfg_keep = 9'd0; cfg_burst = 8'd1;
    cfg_load = 1'b1; start = 1'b1;
    @(posedge clk); #1 cfg_load = 1'b0; start = 1'b0;
    sif.in_data = 8'h3C; sif.in_valid = 1'b1;
    wait_acc(a0, 3, 50);
    sif.in_valid = 1'b0;
    wait_done(d0, 50);
    compare_model(16'hACE1, 9'd256, 3, 8'h3C, q0, errs, drop);
    check("cfg_ign_samples", errs, 0);
    check("cfg_ign_outputs", q_data.size() - q0, 3);
    check("cfg_ign_drop",    int'(drop_count), 0);
    check("cfg_ign_done",    done_cnt - d0, 1);

    // burst 0 means 256; input held valid until done
    a0 = acc_cnt; q0 = q_data.size(); d0 = done_cnt;
    cfg_start(16'hACE1, 9'd256, 8'd0);
    sif.in_data = 8'h81; sif.in_valid = 1'b1;
    wait_done(d0, 400);
    sif.in_valid = 1'b0;
    check("b256_accepts", acc_cnt - a0, 256);
    check("b256_outputs", q_data.size() - q0, 256);
    check("b256_done",    done_cnt - d0, 1);

    // synchronous reset mid-burst
    a0 = acc_cnt; d0 = done_cnt;
    cfg_start(16'hACE1, 9'd128, 8'd8);
    sif.in_data = 8'hFF; sif.in_valid = 1'b1;
    wait_acc(a0, 3, 50);
    reset = 1'b1; sif.in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_busy",      int'(busy), 0);
    check("mrst_out_valid", int'(sif.out_valid), 0);
    check("mrst_out_data",  int'(sif.out_data), 0);
    check("mrst_out_mask",  int'(sif.out_mask), 0);
    check("mrst_drop",      int'(drop_count), 0);
    check("mrst_in_ready",  int'(sif.in_ready), 0);
    repeat (4) @(negedge clk);
    check("mrst_no_done",   done_cnt - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
